sram_frame_arbiter: RTL and testbench
=====================================

// Module: sram_frame_arbiter
// PURPOSE
//  Owns the single 32-bit base SRAM and shares it between two requesters: the display
//  read port (VGA scan-out prefetch, high priority) and the renderer write port (ray
//  pipeline pixel stores). Manages the double frame buffer: buffer select is SRAM
//  addr[19]; swaps read/write buffers at vsync once the renderer has finished a frame.
// PARAMETERS
//  ACC_CYCLES   2       cycles CE/OE (read) or WE (write) held low per access, >=1
//  WR_STARVE    8       max consecutive read grants while wr_req pending, >=1
//  FRAME_WORDS  480000  pixels per frame (800x600); valid offsets 0..FRAME_WORDS-1
// PORTS
//  clk_in       in   1   system clock, 100 MHz
//  reset_btn    in   1   reset, asynchronous, active-high
//  rd_req       in   1   display read request; hold with rd_addr until rd_ack
//  rd_addr      in   19  word offset inside the read buffer
//  rd_ack       out  1   1-cycle pulse: read accepted
//  rd_data      out  32  read data, valid while rd_valid
//  rd_valid     out  1   1-cycle pulse: rd_data updated
//  wr_req       in   1   renderer write request; hold with wr_addr/wr_data until wr_ack
//  wr_addr      in   19  word offset inside the write buffer
//  wr_data      in   32  pixel word {8'h00,R,G,B}
//  wr_ack       out  1   1-cycle pulse: write accepted
//  frame_done   in   1   pulse: renderer finished writing the current frame
//  vsync_start  in   1   pulse: display entered vertical blanking
//  rd_sel       out  1   buffer currently scanned out
//  wr_sel       out  1   buffer currently rendered into (always ~rd_sel)
//  swap_done    out  1   1-cycle pulse: buffers swapped
//  wr_oob       out  1   sticky: a write with wr_addr >= FRAME_WORDS was dropped
//  ram_data     inout 32 SRAM data bus
//  ram_addr     out  20  {sel, offset}
//  ram_be_n     out  4   tied 4'b0000
//  ram_ce_n, ram_oe_n, ram_we_n  out 1 each  SRAM strobes, active-low
// BEHAVIOUR
//  Reset (async): FSM IDLE; ce_n/oe_n/we_n=1; ram_data Z; ram_addr=0; rd_sel=0, wr_sel=1;
//   rd_ack/wr_ack/rd_valid/swap_done=0; rd_data=0; wr_oob=0; swap_pending=0; starve_cnt=0.
//   Reset mid-access aborts it; strobes go high immediately, no ack/valid is issued.
//  FSM states: IDLE, SWAP, RD, WR_SETUP, WR_PULSE, WR_HOLD. All registered outputs.
//  IDLE, priority order: (1) swap_pending && vsync_seen -> SWAP; (2) rd_req -> RD, unless
//   wr_req && starve_cnt==WR_STARVE -> WR_SETUP; (3) wr_req && !swap_pending -> WR_SETUP
//   (or, if wr_addr >= FRAME_WORDS: stay IDLE, pulse wr_ack, set wr_oob, no bus cycle).
//   rd_ack/wr_ack pulse in the first cycle of RD/WR_SETUP; address and data latched then.
//  starve_cnt: +1 per read grant while wr_req high, saturating at WR_STARVE; cleared on write grant.
//  RD: ram_addr={rd_sel,addr}, ce_n=oe_n=0 for ACC_CYCLES cycles; ram_data sampled on last
//   cycle edge into rd_data; rd_valid pulses next cycle (IDLE). Latency req->rd_valid = ACC_CYCLES+1.
//  WR_SETUP 1 cycle: addr/data driven, ce_n=0, we_n=1. WR_PULSE ACC_CYCLES cycles: we_n=0.
//   WR_HOLD 1 cycle: we_n=1, data still driven. Then IDLE; write occupies ACC_CYCLES+2 cycles.
//  ram_data driven only in WR_* states; Z otherwise. Every access returns through one IDLE
//   cycle with all strobes high (bus turnaround); back-to-back accesses are never fused.
//  Swap: frame_done sets swap_pending; vsync_start while swap_pending sets vsync_seen.
//   frame_done and vsync_start in the same cycle -> both set. SWAP (1 cycle, no grant, strobes
//   high): rd_sel<=~rd_sel, wr_sel<=~wr_sel, clear swap_pending/vsync_seen, pulse swap_done.
//   vsync_start without swap_pending: ignored (display repeats old buffer).
//   While swap_pending, writes are stalled (no wr_ack) so the finished frame is not overwritten;
//   reads continue. frame_done while swap_pending: ignored (no double swap).
//  An access already in progress when vsync arrives completes first; swap follows in IDLE.
// TESTING
//  1 Reset, rd_req addr 0x00010, SRAM model returns 0xDEADBEEF -> ram_addr=0x00010, rd_ack at
//    t+1, rd_valid with rd_data=0xDEADBEEF at t+3 (ACC_CYCLES=2); strobes high after.
//  2 wr_req addr 0x00005 data 0x00FF8040 -> ram_addr=0x80005, we_n low exactly 2 cycles,
//    data stable from WR_SETUP through WR_HOLD, wr_ack once.
//  3 rd_req and wr_req held high continuously -> exactly 8 reads then 1 write, repeating;
//    no bus cycle without an intervening IDLE.
//  4 frame_done, then writes stalled; vsync_start 100 cycles later during RD -> RD completes,
//    SWAP: rd_sel=1, wr_sel=0, swap_done pulse; stalled write then goes to 0x0xxxx.
//  5 wr_addr=480000 -> wr_ack, no strobe activity, wr_oob=1 and stays 1 until reset.
//  6 reset_btn asserted mid WR_PULSE -> we_n/ce_n high same cycle, ram_data Z, no wr_ack.

Source files
------------

// File: rtl/sram_frame_arbiter_if.sv
// Requester-side bundle of the frame arbiter: display read port,
// renderer write port and frame/vsync swap control.
interface sram_frame_arbiter_if;
   logic        rd_req;
   logic [18:0] rd_addr;
   logic        rd_ack;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        wr_req;
   logic [18:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_ack;
   logic        frame_done;
   logic        vsync_start;
   logic        rd_sel;
   logic        wr_sel;
   logic        swap_done;
   logic        wr_oob;

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data,
      output frame_done, vsync_start,
      input  rd_ack, rd_data, rd_valid, wr_ack,
      input  rd_sel, wr_sel, swap_done, wr_oob
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
      input  frame_done, vsync_start,
      output rd_ack, rd_data, rd_valid, wr_ack,
      output rd_sel, wr_sel, swap_done, wr_oob
   );
endinterface

// File: rtl/sram_frame_arbiter.sv
// Single-SRAM arbiter: display reads (priority) vs renderer writes,
// with a double frame buffer swapped at vsync after frame_done.
module sram_frame_arbiter #(
   parameter int ACC_CYCLES  = 2,
   parameter int WR_STARVE   = 8,
   parameter int FRAME_WORDS = 480000
) (
   input  logic                    clk_in,
   input  logic                    reset_btn,
   sram_frame_arbiter_if.slave     bus,
   inout  wire  [31:0]             ram_data,
   output logic [19:0]             ram_addr,
   output logic [3:0]              ram_be_n,
   output logic                    ram_ce_n,
   output logic                    ram_oe_n,
   output logic                    ram_we_n
);

   localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
   localparam int SW = $clog2(WR_STARVE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(WR_STARVE);
   localparam logic [19:0] FW = 20'(FRAME_WORDS);

   typedef enum logic [2:0] {
      IDLE, SWAP, RD, WR_SETUP, WR_PULSE, WR_HOLD
   } state_t;

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [19:0] addr_q, addr_d;
   logic [31:0] dout_q, dout_d;
   logic [31:0] rdat_q, rdat_d;
   logic ce_q, ce_d, oe_q, oe_d, we_q, we_d;
   logic drv_q, drv_d;
   logic rack_q, rack_d, wack_q, wack_d;
   logic rval_q, rval_d, swp_q, swp_d;
   logic sel_q, sel_d, oob_q, oob_d;
   logic pend_q, pend_d, seen_q, seen_d;

   logic wr_ok, wr_force, wr_bad;

   // Writes are held off while a finished frame waits for vsync.
   assign wr_ok    = bus.wr_req && !pend_q;
   assign wr_force = wr_ok && (starve_q == STARVE_MAX);
   assign wr_bad   = {1'b0, bus.wr_addr} >= FW;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      starve_d = starve_q;
      addr_d   = addr_q;
      dout_d   = dout_q;
      rdat_d   = rdat_q;
      ce_d     = 1'b1;
      oe_d     = 1'b1;
      we_d     = 1'b1;
      drv_d    = 1'b0;
      rack_d   = 1'b0;
      wack_d   = 1'b0;
      rval_d   = 1'b0;
      swp_d    = 1'b0;
      sel_d    = sel_q;
      oob_d    = oob_q;
      pend_d   = pend_q | bus.frame_done;
      seen_d   = seen_q
               | (bus.vsync_start & (pend_q | bus.frame_done));
      unique case (state_q)
         IDLE: begin
            if (pend_q && seen_q) begin
               state_d = SWAP;
               sel_d   = ~sel_q;
               pend_d  = 1'b0;
               seen_d  = 1'b0;
               swp_d   = 1'b1;
            end else if (bus.rd_req && !wr_force) begin
               state_d = RD;
               rack_d  = 1'b1;
               ce_d    = 1'b0;
               oe_d    = 1'b0;
               cnt_d   = '0;
               addr_d  = {sel_q, bus.rd_addr};
               if (bus.wr_req && starve_q != STARVE_MAX)
                  starve_d = starve_q + 1'b1;
            end else if (wr_ok) begin
               starve_d = '0;
               wack_d   = 1'b1;
               if (wr_bad) begin
                  oob_d = 1'b1;
               end else begin
                  state_d = WR_SETUP;
                  ce_d    = 1'b0;
                  drv_d   = 1'b1;
                  addr_d  = {~sel_q, bus.wr_addr};
                  dout_d  = bus.wr_data;
               end
            end
         end
         SWAP: state_d = IDLE;
         RD: begin
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               rdat_d  = ram_data;
               rval_d  = 1'b1;
            end else begin
               ce_d  = 1'b0;
               oe_d  = 1'b0;
               cnt_d = cnt_q + 1'b1;
            end
         end
         WR_SETUP: begin
            state_d = WR_PULSE;
            ce_d    = 1'b0;
            we_d    = 1'b0;
            drv_d   = 1'b1;
            cnt_d   = '0;
         end
         WR_PULSE: begin
            ce_d  = 1'b0;
            drv_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = WR_HOLD;
            end else begin
               we_d  = 1'b0;
               cnt_d = cnt_q + 1'b1;
            end
         end
         WR_HOLD: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset_btn) begin
      if (reset_btn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         starve_q <= '0;
         addr_q   <= '0;
         dout_q   <= '0;
         rdat_q   <= '0;
         ce_q     <= 1'b1;
         oe_q     <= 1'b1;
         we_q     <= 1'b1;
         drv_q    <= 1'b0;
         rack_q   <= 1'b0;
         wack_q   <= 1'b0;
         rval_q   <= 1'b0;
         swp_q    <= 1'b0;
         sel_q    <= 1'b0;
         oob_q    <= 1'b0;
         pend_q   <= 1'b0;
         seen_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         addr_q   <= addr_d;
         dout_q   <= dout_d;
         rdat_q   <= rdat_d;
         ce_q     <= ce_d;
         oe_q     <= oe_d;
         we_q     <= we_d;
         drv_q    <= drv_d;
         rack_q   <= rack_d;
         wack_q   <= wack_d;
         rval_q   <= rval_d;
         swp_q    <= swp_d;
         sel_q    <= sel_d;
         oob_q    <= oob_d;
         pend_q   <= pend_d;
         seen_q   <= seen_d;
      end
   end

   assign ram_data  = drv_q ? dout_q : 32'bz;
   assign ram_addr  = addr_q;
   assign ram_be_n  = 4'b0000;
   assign ram_ce_n  = ce_q;
   assign ram_oe_n  = oe_q;
   assign ram_we_n  = we_q;

   assign bus.rd_ack    = rack_q;
   assign bus.rd_data   = rdat_q;
   assign bus.rd_valid  = rval_q;
   assign bus.wr_ack    = wack_q;
   assign bus.rd_sel    = sel_q;
   assign bus.wr_sel    = ~sel_q;
   assign bus.swap_done = swp_q;
   assign bus.wr_oob    = oob_q;

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Scoreboard bench for sram_frame_arbiter: stimulus queues expectations,
// a negedge monitor pops them as the arbiter grants, reads and writes.
module tb_sram_frame_arbiter;

   typedef struct {
      logic [19:0] a;
      logic [31:0] d;
   } acc_t;

   logic        clk_in;
   logic        reset_btn;
   wire  [31:0] ram_data;
   logic [19:0] ram_addr;
   logic [3:0]  ram_be_n;
   logic        ram_ce_n, ram_oe_n, ram_we_n;

   sram_frame_arbiter_if bus ();

   sram_frame_arbiter dut (
      .clk_in    (clk_in),
      .reset_btn (reset_btn),
      .bus       (bus),
      .ram_data  (ram_data),
      .ram_addr  (ram_addr),
      .ram_be_n  (ram_be_n),
      .ram_ce_n  (ram_ce_n),
      .ram_oe_n  (ram_oe_n),
      .ram_we_n  (ram_we_n)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // SRAM model: index {buffer, offset[5:0]}
   logic [31:0] mem [0:127];
   logic [6:0]  midx;
   assign midx = {ram_addr[19], ram_addr[5:0]};
   assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem[midx] : 32'bz;
   always @(posedge clk_in)
      if (!ram_ce_n && !ram_we_n) mem[midx] = ram_data;

   int checks = 0;
   int failures = 0;

   acc_t        rd_q[$];
   acc_t        wr_q[$];
   byte         grant_q[$];
   logic [1:0]  swap_q[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm);
      checks++;
      failures++;
      $display("FAIL %s got=event want=none", nm);
   endtask

   // Monitor
   acc_t cur;
   acc_t e;
   int   wlen;
   bit   in_wr;
   logic prev_ce_n;
   byte  k;
   logic [1:0] se;

   always @(negedge clk_in) begin
      if (reset_btn) begin
         in_wr = 1'b0;
         wlen = 0;
         prev_ce_n = 1'b1;
      end else begin
         if (bus.rd_ack || bus.wr_ack) begin
            k = bus.rd_ack ? "R" : (ram_ce_n ? "O" : "W");
            chk("turnaround", 32'(prev_ce_n), 32'd1);
            if (grant_q.size() == 0) unexpected("grant");
            else chk("grant_kind", 32'(k), 32'(grant_q.pop_front()));
            if (k == "R" && rd_q.size() > 0)
               chk("rd_ram_addr", 32'(ram_addr), 32'(rd_q[0].a));
            if (k == "W" && wr_q.size() > 0) begin
               chk("setup_data", ram_data, wr_q[0].d);
               chk("setup_we_n", 32'(ram_we_n), 32'd1);
            end
         end
         if (bus.rd_valid) begin
            if (rd_q.size() == 0) unexpected("rd_valid");
            else begin
               e = rd_q.pop_front();
               chk("rd_data", bus.rd_data, e.d);
            end
            chk("rd_idle_strobes",
                32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h7);
         end
         if (!ram_we_n && !in_wr) begin
            in_wr = 1'b1;
            wlen = 0;
            if (wr_q.size() == 0) unexpected("write");
            else begin
               cur = wr_q.pop_front();
               chk("wr_ram_addr", 32'(ram_addr), 32'(cur.a));
               chk("wr_ram_data", ram_data, cur.d);
            end
         end
         if (!ram_we_n) wlen++;
         else if (in_wr) begin
            in_wr = 1'b0;
            chk("we_len", 32'(wlen), 32'd2);
            chk("hold_data", ram_data, cur.d);
         end
         if (bus.swap_done) begin
            if (swap_q.size() == 0) unexpected("swap_done");
            else begin
               se = swap_q.pop_front();
               chk("swap_sel", 32'({bus.rd_sel, bus.wr_sel}), 32'(se));
            end
         end
         prev_ce_n = ram_ce_n;
      end
   end

   task automatic wait_ack(input bit is_rd, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_in);
         if (is_rd ? bus.rd_ack : bus.wr_ack) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic do_read(input logic [18:0] a, input logic [19:0] ea,
                          input logic [31:0] ed);
      bit ok;
      rd_q.push_back('{ea, ed});
      grant_q.push_back("R");
      bus.rd_req = 1'b1;
      bus.rd_addr = a;
      wait_ack(1'b1, ok);
      bus.rd_req = 1'b0;
      chk("rd_ack_seen", 32'(ok), 32'd1);
      for (int i = 0; i < 10; i++) begin
         if (bus.rd_valid) break;
         @(negedge clk_in);
      end
   endtask

   task automatic do_write(input logic [18:0] a, input logic [31:0] d,
                           input logic [19:0] ea, input bit oob);
      bit ok;
      grant_q.push_back(oob ? "O" : "W");
      if (!oob) wr_q.push_back('{ea, d});
      bus.wr_req = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      wait_ack(1'b0, ok);
      bus.wr_req = 1'b0;
      chk("wr_ack_seen", 32'(ok), 32'd1);
      repeat (6) @(negedge clk_in);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   int ack_lat, val_lat, nw;
   bit ok, found;

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i);
      mem[7'h10] = 32'hDEADBEEF;
      reset_btn = 1'b1;
      bus.rd_req = 1'b0;
      bus.rd_addr = '0;
      bus.wr_req = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.frame_done = 1'b0;
      bus.vsync_start = 1'b0;
      repeat (3) @(negedge clk_in);
      chk("rst_rd_sel", 32'(bus.rd_sel), 32'd0);
      chk("rst_wr_sel", 32'(bus.wr_sel), 32'd1);
      chk("rst_wr_oob", 32'(bus.wr_oob), 32'd0);
      chk("rst_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h7);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_rd_data", bus.rd_data, 32'd0);
      chk("rst_be_n", 32'(ram_be_n), 32'd0);
      reset_btn = 1'b0;
      @(negedge clk_in);

      // read latency
      rd_q.push_back('{20'h00010, 32'hDEADBEEF});
      grant_q.push_back("R");
      bus.rd_req = 1'b1;
      bus.rd_addr = 19'h00010;
      ack_lat = -1;
      val_lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk_in);
         if (bus.rd_ack) begin
            ack_lat = i;
            bus.rd_req = 1'b0;
         end
         if (bus.rd_valid) begin
            val_lat = i;
            break;
         end
      end
      bus.rd_req = 1'b0;
      chk("ack_latency", 32'(ack_lat), 32'd1);
      chk("valid_latency", 32'(val_lat), 32'd3);
      @(negedge clk_in);
      chk("post_rd_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h7);

      // single write into buffer 1
      do_write(19'h00005, 32'h00FF8040, 20'h80005, 1'b0);

      // write starvation: 8 reads then 1 write, twice
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 8; i++) begin
            rd_q.push_back('{20'h00020, 32'h1000_0020});
            grant_q.push_back("R");
         end
         grant_q.push_back("W");
         wr_q.push_back('{20'h80007, 32'h00112233});
      end
      bus.rd_req = 1'b1;
      bus.rd_addr = 19'h00020;
      bus.wr_req = 1'b1;
      bus.wr_addr = 19'h00007;
      bus.wr_data = 32'h00112233;
      nw = 0;
      for (int i = 0; i < 300 && nw < 2; i++) begin
         @(negedge clk_in);
         if (bus.wr_ack) nw++;
      end
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
      chk("starve_writes", 32'(nw), 32'd2);
      repeat (8) @(negedge clk_in);

      // frame swap with a stalled write
      bus.frame_done = 1'b1;
      @(negedge clk_in);
      bus.frame_done = 1'b0;
      bus.wr_req = 1'b1;
      bus.wr_addr = 19'h00008;
      bus.wr_data = 32'h00ABCDEF;
      wr_q.push_back('{20'h00008, 32'h00ABCDEF});
      repeat (3) do_read(19'h00021, 20'h00021, 32'h1000_0021);
      repeat (80) @(negedge clk_in);
      chk("stall_rd_sel", 32'(bus.rd_sel), 32'd0);
      swap_q.push_back(2'b10);
      rd_q.push_back('{20'h00021, 32'h1000_0021});
      grant_q.push_back("R");
      bus.rd_req = 1'b1;
      bus.rd_addr = 19'h00021;
      wait_ack(1'b1, ok);
      bus.rd_req = 1'b0;
      bus.vsync_start = 1'b1;
      grant_q.push_back("W");
      chk("vsync_rd_ack", 32'(ok), 32'd1);
      @(negedge clk_in);
      bus.vsync_start = 1'b0;
      wait_ack(1'b0, ok);
      bus.wr_req = 1'b0;
      chk("stalled_wr_ack", 32'(ok), 32'd1);
      repeat (6) @(negedge clk_in);
      do_read(19'h00005, 20'h80005, 32'h00FF8040);
      do_read(19'h00006, 20'h80006, 32'h1000_0046);

      // vsync with no finished frame is ignored
      bus.vsync_start = 1'b1;
      @(negedge clk_in);
      bus.vsync_start = 1'b0;
      repeat (4) @(negedge clk_in);
      chk("no_swap_rd_sel", 32'(bus.rd_sel), 32'd1);

      // out-of-range write
      chk("pre_oob", 32'(bus.wr_oob), 32'd0);
      do_write(19'd480000, 32'h0, 20'h0, 1'b1);
      chk("wr_oob_set", 32'(bus.wr_oob), 32'd1);
      do_read(19'h00006, 20'h80006, 32'h1000_0046);
      chk("wr_oob_sticky", 32'(bus.wr_oob), 32'd1);

      // reset during the write pulse
      grant_q.push_back("W");
      wr_q.push_back('{20'h00009, 32'h00000001});
      bus.wr_req = 1'b1;
      bus.wr_addr = 19'h00009;
      bus.wr_data = 32'h00000001;
      wait_ack(1'b0, ok);
      bus.wr_req = 1'b0;
      chk("rst_wr_ack", 32'(ok), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_in);
         if (!ram_we_n) begin
            found = 1'b1;
            break;
         end
      end
      chk("we_pulse_seen", 32'(found), 32'd1);
      #2 reset_btn = 1'b1;
      #1;
      chk("async_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h7);
      chk("async_wr_ack", 32'(bus.wr_ack), 32'd0);
      repeat (2) @(negedge clk_in);
      chk("rerst_rd_sel", 32'(bus.rd_sel), 32'd0);
      chk("rerst_wr_oob", 32'(bus.wr_oob), 32'd0);
      reset_btn = 1'b0;
      repeat (5) @(negedge clk_in);
      do_read(19'h00010, 20'h00010, 32'hDEADBEEF);
      repeat (4) @(negedge clk_in);

      chk("grant_q_empty", 32'(grant_q.size()), 32'd0);
      chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
      chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
      chk("swap_q_empty", 32'(swap_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
